mult_share_ctrl: RTL and testbench
==================================

// Module: mult_share_ctrl
// PURPOSE
//  Sequences and shares one 32x32 signed Wallace tree multiplier (WallaceTreeMulti: A,B -> 64-bit Result)
//  between two requesters via valid/ready handshakes. Operands are registered and the multiplier is a
//  MULT_CYCLES multicycle path. The product is registered and returned with the requester ID.
//  Sits between ALU issue logic and the tree multiplier.
// PARAMETERS
//  MULT_CYCLES  2   cycles allotted to the combinational multiplier path; legal range 1..15
//  CNT_W        4   width of the internal cycle counter; must hold MULT_CYCLES
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  req0_valid   in   1   requester 0 has an operation
//  req0_ready   out  1   requester 0 accepted this cycle (valid&ready = handshake)
//  req0_a       in   32  requester 0 operand A (two's complement)
//  req0_b       in   32  requester 0 operand B (two's complement)
//  req1_valid   in   1   requester 1 has an operation
//  req1_ready   out  1   requester 1 accepted this cycle
//  req1_a       in   32  requester 1 operand A
//  req1_b       in   32  requester 1 operand B
//  rsp_valid    out  1   rsp_result/rsp_id valid
//  rsp_ready    in   1   consumer takes the response
//  rsp_id       out  1   requester the response belongs to
//  rsp_result   out  64  signed product A*B
//  busy         out  1   high whenever state != IDLE
//  ops_done     out  16  count of completed response handshakes, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Reset (async): state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, ops_done=0, cnt=0.
//    last_id=1, so port 0 wins the first tie. req*_ready are forced to 0 while rst=1.
//  - FSM IDLE -> CALC -> RESP -> IDLE. One operation in flight; no overlap of response and accept.
//  - IDLE: grant = both valid ? ~last_id : (req1_valid & ~req0_valid).
//    req<grant>_ready=1 combinationally, only in IDLE, only if that req is valid.
//    The other ready is 0. Ready never depends on rsp_ready.
//  - On accept (edge E0): op_a/op_b/op_id <= granted operands; last_id <= grant; cnt <= MULT_CYCLES;
//    state <= CALC.
//  - CALC: multiplier is fed only from op_a/op_b, which are stable for the whole state.
//    cnt decrements each cycle. In the cycle with cnt==1: rsp_result <= Result, rsp_id <= op_id,
//    rsp_valid <= 1, state <= RESP.
//    First cycle rsp_valid=1 is the cycle after edge E0+MULT_CYCLES.
//  - RESP: rsp_valid, rsp_id and rsp_result hold stable until rsp_ready=1.
//    On that handshake edge: rsp_valid <= 0, ops_done <= ops_done+1 (mod 2^16), state <= IDLE.
//    rsp_result keeps its last value.
//  - Throughput: at most one op per MULT_CYCLES+2 cycles. The IDLE accept cycle is not merged with
//    the RESP handshake.
//  - Requester inputs are sampled only at the handshake. Changes while not ready are ignored.
//    A requester deasserting valid before ready drops its request; this is legal.
//  - Arithmetic: full signed 64-bit product, no truncation or saturation.
//    Examples: -2^31 * -2^31 = +2^62; 0 * x = 0.
//  - Reset mid-CALC/RESP: the in-flight op is discarded with no response, and all outputs take reset
//    values immediately. Arbitration restarts with port 0 priority.
//  - rst deassertion is synchronised externally; the first accept happens at the earliest on the
//    first rising edge with rst=0.
// TESTING
//  1. MULT_CYCLES=2; req0 a=7, b=-3 -> accept at E0; rsp_valid rises after E0+2;
//     rsp_result=64'hFFFF_FFFF_FFFF_FFEB, rsp_id=0, ops_done=1.
//  2. req0/req1 valid every cycle, rsp_ready=1, 4 ops -> grant order 0,1,0,1; ops_done=4;
//     never both readies high.
//  3. rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_result/rsp_id stable,
//     req*_ready=0, busy=1.
//  4. a=b=32'h8000_0000 -> 64'h4000_0000_0000_0000;
//     a=32'h7FFF_FFFF, b=32'h8000_0000 -> 64'hC000_0000_8000_0000.
//  5. Assert rst mid-CALC -> all outputs 0 asynchronously. After release, both valid -> port 0
//     granted first; no stale response appears.
//  6. Sweep MULT_CYCLES=1 and 15 with random signed operands vs. a reference model ->
//     exact products and latency.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// Shares one 32x32 signed multiplier between two valid/ready requesters.
// Operands are held in registers for the whole multicycle window.
module mult_share_ctrl #(
   parameter int MULT_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [63:0] rsp_result,
   output logic        busy,
   output logic [15:0] ops_done
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      op_a_q, op_a_d;
   logic [31:0]      op_b_q, op_b_d;
   logic             op_id_q, op_id_d;
   logic             last_id_q, last_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [63:0]      rsp_result_q, rsp_result_d;
   logic [15:0]      ops_done_q, ops_done_d;

   logic             grant;
   logic             idle_ok;
   logic             acc0, acc1;
   logic [63:0]      mul_a, mul_b;
   logic [63:0]      mul_res;

   // Tree multiplier: fed only from the operand registers.
   always_comb begin
      mul_a   = {{32{op_a_q[31]}}, op_a_q};
      mul_b   = {{32{op_b_q[31]}}, op_b_q};
      mul_res = $signed(mul_a) * $signed(mul_b);
   end

   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_id_q;
      end else begin
         grant = req1_valid & ~req0_valid;
      end
   end

   assign idle_ok    = (state_q == IDLE) & ~rst;
   assign acc0       = idle_ok & req0_valid & ~grant;
   assign acc1       = idle_ok & req1_valid & grant;
   assign req0_ready = acc0;
   assign req1_ready = acc1;

   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_id_d      = op_id_q;
      last_id_d    = last_id_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      ops_done_d   = ops_done_q;
      unique case (state_q)
         IDLE: begin
            if (acc0 || acc1) begin
               op_a_d    = acc1 ? req1_a : req0_a;
               op_b_d    = acc1 ? req1_b : req0_b;
               op_id_d   = acc1;
               last_id_d = acc1;
               cnt_d     = CNT_W'(MULT_CYCLES);
               state_d   = CALC;
            end
         end
         CALC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               rsp_result_d = mul_res;
               rsp_id_d     = op_id_q;
               rsp_valid_d  = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               ops_done_d  = ops_done_q + 16'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_id_q      <= 1'b0;
         last_id_q    <= 1'b1;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         ops_done_q   <= '0;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_id_q      <= op_id_d;
         last_id_q    <= last_id_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign busy       = (state_q != IDLE);
   assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: instances with MULT_CYCLES 1, 2, 15
// share stimulus; most steps observe the MULT_CYCLES=2 instance.
module tb_mult_share_ctrl;

   logic        clk;
   logic        rst;
   logic        v0, v1, rrdy;
   logic [31:0] a0, b0, a1, b1;

   logic        r0r [3];
   logic        r1r [3];
   logic        rv  [3];
   logic        rid [3];
   logic        bsy [3];
   logic [63:0] res [3];
   logic [15:0] ops [3];

   int vectors = 0;
   int errs    = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int MC = (g == 0) ? 1 : (g == 1) ? 2 : 15;
      mult_share_ctrl #(.MULT_CYCLES(MC), .CNT_W(4)) dut (
         .clk        (clk),
         .rst        (rst),
         .req0_valid (v0),
         .req0_ready (r0r[g]),
         .req0_a     (a0),
         .req0_b     (b0),
         .req1_valid (v1),
         .req1_ready (r1r[g]),
         .req1_a     (a1),
         .req1_b     (b1),
         .rsp_valid  (rv[g]),
         .rsp_ready  (rrdy),
         .rsp_id     (rid[g]),
         .rsp_result (res[g]),
         .busy       (bsy[g]),
         .ops_done   (ops[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mref(input logic [31:0] a,
                                        input logic [31:0] b);
      logic signed [63:0] x, y;
      x = {{32{a[31]}}, a};
      y = {{32{b[31]}}, b};
      return 64'(x * y);
   endfunction

   initial begin
      logic [31:0] ta [6];
      logic [31:0] tb_ [6];
      int          first [3];
      logic [63:0] got [3];
      int          lat [3];
      int          nrsp;
      logic        both;
      logic        exp_id [4];
      logic [63:0] exp_res [4];

      rst = 1'b1; rrdy = 1'b0;
      v0 = 1'b1; a0 = 32'd7; b0 = -32'sd3;
      v1 = 1'b0; a1 = '0; b1 = '0;

      // reset state, readies forced low during reset
      tick();
      chk("rst_rsp_valid", 64'(rv[1]), 64'd0);
      chk("rst_rsp_result", res[1], 64'd0);
      chk("rst_rsp_id", 64'(rid[1]), 64'd0);
      chk("rst_busy", 64'(bsy[1]), 64'd0);
      chk("rst_ops_done", 64'(ops[1]), 64'd0);
      chk("rst_req0_ready", 64'(r0r[1]), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("t1_req0_ready", 64'(r0r[1]), 64'd1);
      chk("t1_req1_ready", 64'(r1r[1]), 64'd0);
      tick();
      v0 = 1'b0;
      chk("t1_busy", 64'(bsy[1]), 64'd1);
      chk("t1_rv_e0", 64'(rv[1]), 64'd0);
      tick();
      chk("t1_rv_e1", 64'(rv[1]), 64'd0);
      tick();
      chk("t1_rv_e2", 64'(rv[1]), 64'd1);
      chk("t1_result", res[1], 64'hFFFF_FFFF_FFFF_FFEB);
      chk("t1_id", 64'(rid[1]), 64'd0);
      rrdy = 1'b1;
      tick();
      chk("t1_ops_done", 64'(ops[1]), 64'd1);
      chk("t1_rv_drop", 64'(rv[1]), 64'd0);
      chk("t1_idle", 64'(bsy[1]), 64'd0);

      // response stalled for 10 cycles, readies held low
      rrdy = 1'b0;
      v1 = 1'b1; a1 = 32'h8000_0000; b1 = 32'h8000_0000;
      #1;
      chk("t3_req1_ready", 64'(r1r[1]), 64'd1);
      tick();
      v0 = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 10; k++) begin
         chk("t3_rv", 64'(rv[1]), 64'd1);
         chk("t3_result", res[1], 64'h4000_0000_0000_0000);
         chk("t3_id", 64'(rid[1]), 64'd1);
         chk("t3_r0", 64'(r0r[1]), 64'd0);
         chk("t3_r1", 64'(r1r[1]), 64'd0);
         chk("t3_busy", 64'(bsy[1]), 64'd1);
         tick();
      end
      v0 = 1'b0; v1 = 1'b0;
      rrdy = 1'b1;
      tick();
      chk("t3_ops_done", 64'(ops[1]), 64'd2);

      // zero operand, then max positive times min negative
      v1 = 1'b1; a1 = 32'd0; b1 = 32'h1234_5678;
      tick();
      v1 = 1'b0;
      tick();
      tick();
      chk("t4_zero", res[1], 64'd0);
      tick();
      v0 = 1'b1; a0 = 32'h7FFF_FFFF; b0 = 32'h8000_0000;
      tick();
      v0 = 1'b0;
      tick();
      tick();
      chk("t4_maxmin", res[1], 64'hC000_0000_8000_0000);
      tick();
      chk("t4_ops_done", 64'(ops[1]), 64'd4);

      // reset in the middle of CALC
      v1 = 1'b1; a1 = 32'd3; b1 = 32'd3;
      tick();
      v1 = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("t5_busy", 64'(bsy[1]), 64'd0);
      chk("t5_rv", 64'(rv[1]), 64'd0);
      chk("t5_result", res[1], 64'd0);
      chk("t5_ops_done", 64'(ops[1]), 64'd0);
      tick();
      rst = 1'b0;

      // both requesters always valid: alternate starting at port 0
      v0 = 1'b1; a0 = 32'd5; b0 = 32'd6;
      v1 = 1'b1; a1 = -32'sd4; b1 = 32'd9;
      exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_res = '{64'd30, 64'hFFFF_FFFF_FFFF_FFDC,
                  64'd30, 64'hFFFF_FFFF_FFFF_FFDC};
      nrsp = 0;
      both = 1'b0;
      #1;
      for (int c = 0; c < 40 && nrsp < 4; c++) begin
         if (r0r[1] && r1r[1]) both = 1'b1;
         if (rv[1]) begin
            chk("t2_id", 64'(rid[1]), 64'(exp_id[nrsp]));
            chk("t2_result", res[1], exp_res[nrsp]);
            nrsp++;
         end
         tick();
      end
      v0 = 1'b0; v1 = 1'b0;
      chk("t2_rsp_count", 64'(nrsp), 64'd4);
      chk("t2_dual_ready", 64'(both), 64'd0);
      chk("t2_ops_done", 64'(ops[1]), 64'd4);

      // latency and products for MULT_CYCLES 1, 2 and 15
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ta  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0};
      tb_ = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1, 0, 0, 0};
      for (int v = 3; v < 6; v++) begin
         ta[v]  = $urandom;
         tb_[v] = $urandom;
      end
      lat = '{1, 2, 15};
      for (int v = 0; v < 6; v++) begin
         v0 = 1'b1; a0 = ta[v]; b0 = tb_[v];
         tick();
         v0 = 1'b0;
         for (int i = 0; i < 3; i++) begin
            first[i] = -1;
            got[i]   = '0;
         end
         for (int k = 1; k <= 20; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
               if (rv[i] && first[i] < 0) begin
                  first[i] = k;
                  got[i]   = res[i];
               end
            end
         end
         for (int i = 0; i < 3; i++) begin
            chk("t6_latency", 64'(first[i]), 64'(lat[i]));
            chk("t6_product", got[i], mref(ta[v], tb_[v]));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
